// File: rtl/dp_share_arbiter_pkg.sv
// Shared types, widths and the response signature fold for the datapath share arbiter.
package dp_share_pkg;

  localparam int unsigned DP_IN_W    = 41;
  localparam int unsigned DP_OUT_W   = 769;
  localparam int unsigned SIG_W      = 16;
  localparam int unsigned SIG_SLICES = (DP_OUT_W + SIG_W - 1) / SIG_W;
  localparam int unsigned SIG_PAD_W  = SIG_SLICES * SIG_W;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    RESP
  } dp_share_state_t;

  // XOR of all SIG_W-bit slices of y; the top slice is zero-padded.
  function automatic logic [SIG_W-1:0] sig_fold(input logic [DP_OUT_W-1:0] y);
    logic [SIG_PAD_W-1:0] p;
    logic [SIG_W-1:0]     s;
    p = SIG_PAD_W'(y);
    s = '0;
    for (int i = 0; i < int'(SIG_SLICES); i++) begin
      s = s ^ p[i*SIG_W +: SIG_W];
    end
    return s;
  endfunction

endpackage

// File: rtl/dp_share_arbiter_if.sv
// Requester, datapath and response signals around the datapath share arbiter.
interface dp_share_if
  import dp_share_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IN_W  = DP_IN_W,
  parameter int unsigned OUT_W = DP_OUT_W
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      dp_in;
  logic [OUT_W-1:0]     dp_out;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic [SIG_W-1:0]     rsp_sig;
  logic                 busy;

  // Requesters, datapath and response consumer side.
  modport master (
    output req_valid, req_data, dp_out, rsp_ready,
    input  req_ready, dp_in, rsp_valid, rsp_id, rsp_data, rsp_sig, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, dp_out, rsp_ready,
    output req_ready, dp_in, rsp_valid, rsp_id, rsp_data, rsp_sig, busy
  );

endinterface

// File: rtl/dp_share_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request searching upward from ptr, modulo NREQ.
module rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  logic [IW-1:0] k;

  // Scan from farthest to nearest so the request closest to ptr wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k     = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      k = IW'((int'(ptr_i) + i) % int'(NREQ));
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/dp_share_arbiter.sv
// Time-shares one datapath between NREQ requesters: round-robin accept, settle, capture, respond.
// Optional feature: DP_SHARE_SIG_EN registers an XOR-fold signature of the captured response.
module dp_share_arbiter
  import dp_share_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned IN_W   = DP_IN_W,
  parameter int unsigned OUT_W  = DP_OUT_W,
  parameter int unsigned SETTLE = 3
) (
  input logic      clk,
  input logic      rst,
  dp_share_if.slave bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  dp_share_state_t  state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IN_W-1:0]  dp_in_q, dp_in_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]  gnt;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  req_ready_c;
  logic             accept_c;
  logic             capture_c;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready_c = (state_q == IDLE && !rst) ? gnt : '0;
  assign accept_c    = |req_ready_c;
  assign capture_c   = (state_q == APPLY) && (cnt_q == 8'd0);

  // Next-state and datapath/response register updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    dp_in_d     = dp_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          dp_in_d = bus.req_data[gnt_idx*IN_W +: IN_W];
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = 8'(SETTLE - 1);
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (capture_c) begin
          rsp_data_d  = bus.dp_out;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      dp_in_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      dp_in_q     <= dp_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef DP_SHARE_SIG_EN
  logic [SIG_W-1:0] rsp_sig_q, rsp_sig_d;

  assign rsp_sig_d = capture_c ? sig_fold(DP_OUT_W'(bus.dp_out)) : rsp_sig_q;

  always_ff @(posedge clk) begin
    if (rst) rsp_sig_q <= '0;
    else     rsp_sig_q <= rsp_sig_d;
  end

  assign bus.rsp_sig = rsp_sig_q;
`else
  assign bus.rsp_sig = '0;
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.dp_in     = dp_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Directed self-checking bench for dp_share_arbiter; dp_out is a cycle-count pattern or all ones.
module tb_dp_share_arbiter;
  import dp_share_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned IN_W   = 41;
  localparam int unsigned OUT_W  = 769;
  localparam int unsigned SETTLE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  bit dp_ones = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  dp_share_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  dp_share_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OUT_W-1:0] pat(input int unsigned c);
    logic [799:0] w;
    w = {25{c}};
    return w[OUT_W-1:0];
  endfunction

  assign bus.dp_out = dp_ones ? {OUT_W{1'b1}} : pat(cyc);

  // Bitwise model: bit i of the signature is the XOR of every y bit at position i mod 16.
  function automatic logic [15:0] exp_sig(input logic [OUT_W-1:0] v);
    logic [15:0] s;
    s = 16'h0;
`ifdef DP_SHARE_SIG_EN
    for (int i = 0; i < int'(OUT_W); i++) s[i % 16] = s[i % 16] ^ v[i];
`endif
    return s;
  endfunction

  function automatic logic [IN_W-1:0] rd(input int i);
    return 41'h1AB_CDEF_0120 + IN_W'(i * 41'h11);
  endfunction

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    tick();
    tick();
    #1;
    chk("rst_req_ready", OUT_W'(bus.req_ready), OUT_W'(4'b0000));
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  task automatic wait_rsp(input int maxc);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    if (bus.rsp_valid !== 1'b1) chk("rsp_timeout", OUT_W'(bus.rsp_valid), OUT_W'(1'b1));
  endtask

  int unsigned c0;
  logic [OUT_W-1:0] held;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset values and single request latency
    do_reset();
    #1;
    chk("rst_dp_in", OUT_W'(bus.dp_in), '0);
    chk("rst_rsp_valid", OUT_W'(bus.rsp_valid), '0);
    chk("rst_busy", OUT_W'(bus.busy), '0);
    chk("rst_rsp_id", OUT_W'(bus.rsp_id), '0);
    chk("rst_rsp_data", bus.rsp_data, '0);
    chk("rst_rsp_sig", OUT_W'(bus.rsp_sig), '0);
    bus.req_data[0 +: IN_W] = 41'h1_2345_6789;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    chk("t1_ready", OUT_W'(bus.req_ready), OUT_W'(4'b0001));
    c0 = cyc;
    tick();
    bus.req_valid = '0;
    #1;
    chk("t1_dp_in", OUT_W'(bus.dp_in), OUT_W'(41'h1_2345_6789));
    chk("t1_busy", OUT_W'(bus.busy), OUT_W'(1'b1));
    chk("t1_ready_apply", OUT_W'(bus.req_ready), '0);
    tick();
    tick();
    #1;
    chk("t1_no_rsp_early", OUT_W'(bus.rsp_valid), '0);
    tick();
    #1;
    chk("t1_rsp_valid", OUT_W'(bus.rsp_valid), OUT_W'(1'b1));
    chk("t1_rsp_id", OUT_W'(bus.rsp_id), '0);
    chk("t1_rsp_data", bus.rsp_data, pat(c0 + 3));
    chk("t1_rsp_sig", OUT_W'(bus.rsp_sig), OUT_W'(exp_sig(pat(c0 + 3))));
    tick();
    #1;
    chk("t1_idle_busy", OUT_W'(bus.busy), '0);
    chk("t1_rsp_done", OUT_W'(bus.rsp_valid), '0);

    // Round robin with all requesters active
    do_reset();
    for (int i = 0; i < int'(NREQ); i++) bus.req_data[i*IN_W +: IN_W] = rd(i);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk($sformatf("rr_gnt%0d", g), OUT_W'(bus.req_ready), OUT_W'(4'b0001 << (g % 4)));
      c0 = cyc;
      tick();
      #1;
      chk($sformatf("rr_dp_in%0d", g), OUT_W'(bus.dp_in), OUT_W'(rd(g % 4)));
      tick();
      tick();
      tick();
      #1;
      chk($sformatf("rr_rsp_id%0d", g), OUT_W'(bus.rsp_id), OUT_W'(g % 4));
      chk($sformatf("rr_rsp_data%0d", g), bus.rsp_data, pat(c0 + 3));
      tick();
    end
    bus.req_valid = '0;

    // Back-pressure: response held while rsp_ready is low
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_gnt", OUT_W'(bus.req_ready), OUT_W'(4'b0100));
    c0 = cyc;
    tick();
    bus.req_valid = 4'b1111;
    tick();
    tick();
    tick();
    held = pat(c0 + 3);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_rsp_valid", OUT_W'(bus.rsp_valid), OUT_W'(1'b1));
      chk("bp_rsp_id", OUT_W'(bus.rsp_id), OUT_W'(2));
      chk("bp_rsp_data", bus.rsp_data, held);
      chk("bp_ready", OUT_W'(bus.req_ready), '0);
      chk("bp_dp_in", OUT_W'(bus.dp_in), OUT_W'(rd(2)));
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_next_gnt", OUT_W'(bus.req_ready), OUT_W'(4'b1000));
    bus.req_valid = '0;

    // Reset in the middle of APPLY drops the request and clears ptr
    tick();
    bus.req_valid = 4'b0010;
    #1;
    chk("mr_gnt", OUT_W'(bus.req_ready), OUT_W'(4'b0010));
    tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_busy", OUT_W'(bus.busy), '0);
    chk("mr_dp_in", OUT_W'(bus.dp_in), '0);
    chk("mr_rsp_valid", OUT_W'(bus.rsp_valid), '0);
    chk("mr_rsp_data", bus.rsp_data, '0);
    bus.req_valid = 4'b1010;
    #1;
    chk("mr_ptr0_gnt", OUT_W'(bus.req_ready), OUT_W'(4'b0010));
    tick();
    bus.req_valid = '0;
    #1;
    chk("mr_dropped_a", OUT_W'(bus.rsp_valid), '0);
    tick();
    tick();
    #1;
    chk("mr_dropped_b", OUT_W'(bus.rsp_valid), '0);
    tick();
    #1;
    chk("mr_new_rsp", OUT_W'(bus.rsp_valid), OUT_W'(1'b1));
    chk("mr_new_id", OUT_W'(bus.rsp_id), OUT_W'(1));
    tick();
    bus.req_valid = 4'b0100;
    #1;
    chk("mr_gnt2", OUT_W'(bus.req_ready), OUT_W'(4'b0100));
    tick();
    bus.req_valid = '0;
    wait_rsp(8);
    #1;
    chk("mr_rsp_id2", OUT_W'(bus.rsp_id), OUT_W'(2));
    tick();

    // All-ones datapath output and signature
    dp_ones = 1'b1;
    bus.req_valid = 4'b0001;
    #1;
    chk("ones_gnt", OUT_W'(bus.req_ready), OUT_W'(4'b0001));
    tick();
    bus.req_valid = '0;
    wait_rsp(8);
    #1;
    chk("ones_data", bus.rsp_data, {OUT_W{1'b1}});
`ifdef DP_SHARE_SIG_EN
    chk("ones_sig", OUT_W'(bus.rsp_sig), OUT_W'(16'h0001));
`else
    chk("ones_sig", OUT_W'(bus.rsp_sig), OUT_W'(16'h0000));
`endif
    tick();
    dp_ones = 1'b0;

    // Short req_valid[3] pulse while busy is ignored
    bus.req_valid = 4'b0001;
    #1;
    chk("pulse_gnt0", OUT_W'(bus.req_ready), OUT_W'(4'b0001));
    tick();
    bus.req_valid = 4'b1000;
    #1;
    chk("pulse_ready_apply", OUT_W'(bus.req_ready), '0);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    #1;
    chk("pulse_rsp_valid", OUT_W'(bus.rsp_valid), OUT_W'(1'b1));
    chk("pulse_rsp_id", OUT_W'(bus.rsp_id), '0);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("pulse_no_gnt3", OUT_W'(bus.req_ready), '0);
      chk("pulse_no_rsp", OUT_W'(bus.rsp_valid), '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
